encoder_round_sequencer: RTL and testbench

Parametrised top-level controller for the encoder flow. It brackets a multi-round, multi-stage computation with the file read/write handshakes: datapath reset plus file read, then `NUM_STAGES` stage engines run in order for `num_rounds` rounds, then file write and finish. Each stage engine uses a one-cycle start pulse and a done pulse. The block adds a watchdog timeout, an abort input and busy/progress outputs, and sits between the testbench/file layer and the stage datapaths.

---
 rtl/encoder_pkg.sv | 34 +++
 rtl/stage_timeout_counter.sv | 38 +++
 rtl/encoder_round_sequencer.sv | 146 ++++++++++++++
 tb/tb_encoder_round_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared state encoding and default parameters for the encoder round sequencer.
package encoder_pkg;

  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_TIMEOUT    = 1024;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_INIT   = 4'd1;
  localparam logic [3:0] S_READ   = 4'd2;
  localparam logic [3:0] S_LAUNCH = 4'd3;
  localparam logic [3:0] S_WAIT   = 4'd4;
  localparam logic [3:0] S_NEXT   = 4'd5;
  localparam logic [3:0] S_WRITE  = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERROR  = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE   = S_IDLE,
    ST_INIT   = S_INIT,
    ST_READ   = S_READ,
    ST_LAUNCH = S_LAUNCH,
    ST_WAIT   = S_WAIT,
    ST_NEXT   = S_NEXT,
    ST_WRITE  = S_WRITE,
    ST_DONE   = S_DONE,
    ST_ERROR  = S_ERROR
  } state_t;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stage_timeout_counter.sv
// Per-stage watchdog: cleared on launch, counts enabled WAIT cycles, saturates at TIMEOUT-1.
// o_expire is combinational from the count; tied low when TIMEOUT is 0.
module stage_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst, i_clr, i_en};
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign o_expire = (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/encoder_round_sequencer.sv
// Job controller: INIT/READ, then NUM_STAGES stage engines per round for num_rounds rounds, then WRITE.
// Moore outputs; a stage is LAUNCH + k WAIT cycles + NEXT; a silent stage ends the job via ERROR.
module encoder_round_sequencer
  import encoder_pkg::*;
#(
  parameter int  NUM_STAGES = DEF_NUM_STAGES,
  parameter int  ROUND_W    = 5,
  parameter int  TIMEOUT    = DEF_TIMEOUT,
  localparam int STAGE_W    = idx_width(NUM_STAGES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ROUND_W-1:0]    i_num_rounds,
  input  logic [NUM_STAGES-1:0] i_stage_done,
  output logic                  o_dp_rst,
  output logic                  o_read_file,
  output logic                  o_write_file,
  output logic [NUM_STAGES-1:0] o_stage_start,
  output logic                  o_finish,
  output logic                  o_busy,
  output logic                  o_timeout_err,
  output logic [STAGE_W-1:0]    o_stage_idx,
  output logic [ROUND_W-1:0]    o_round_idx
);

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [STAGE_W-1:0]   r_stage_idx;
  logic [ROUND_W-1:0]   r_round_idx;
  logic [ROUND_W-1:0]   r_num_rounds;
  logic                 r_timeout_err;
  logic                 w_tmr_clr;
  logic                 w_tmr_en;
  logic                 w_expire;
  logic                 w_done;
  logic                 w_last_stage;
  logic                 w_last_round;
  logic                 w_accept;

  // Only the engine currently being waited on is allowed to complete the stage.
  assign w_done       = i_stage_done[r_stage_idx];
  assign w_last_stage = (r_stage_idx == LAST_STAGE);
  assign w_last_round = (r_round_idx == (r_num_rounds - ROUND_W'(1)));
  assign w_accept     = (r_state == ST_IDLE) && i_start;

  stage_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_tmr_clr = 1'b0;
    w_tmr_en  = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_start) w_next = ST_INIT;
      ST_INIT:   w_next = ST_READ;
      ST_READ:   w_next = (r_num_rounds == '0) ? ST_WRITE : ST_LAUNCH;
      ST_LAUNCH: begin
        w_tmr_clr = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done) begin
          w_next = ST_NEXT;
        end else if (w_expire) begin
          w_next = ST_ERROR;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_NEXT:   w_next = (w_last_stage && w_last_round) ? ST_WRITE : ST_LAUNCH;
      ST_WRITE:  w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      ST_ERROR:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    // Abort cancels everything outside IDLE, including a same-cycle done.
    if (i_abort && (r_state != ST_IDLE)) begin
      w_next   = ST_IDLE;
      w_tmr_en = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_num_rounds <= '0;
      r_stage_idx  <= '0;
      r_round_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_num_rounds <= i_num_rounds;
      end
      if (r_state == ST_READ) begin
        r_stage_idx <= '0;
        r_round_idx <= '0;
      end else if ((r_state == ST_NEXT) && (w_next == ST_LAUNCH)) begin
        if (w_last_stage) begin
          r_stage_idx <= '0;
          r_round_idx <= r_round_idx + ROUND_W'(1);
        end else begin
          r_stage_idx <= r_stage_idx + STAGE_W'(1);
        end
      end
    end
  end

  // Sticky across IDLE so the caller can inspect it after finish.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_accept) begin
      r_timeout_err <= 1'b0;
    end else if (w_next == ST_ERROR) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_dp_rst      = (r_state == ST_INIT);
  assign o_read_file   = (r_state == ST_INIT);
  assign o_write_file  = (r_state == ST_WRITE);
  assign o_stage_start = (r_state == ST_LAUNCH) ? (NUM_STAGES'(1) << r_stage_idx) : '0;
  assign o_finish      = (r_state == ST_DONE) || (r_state == ST_ERROR);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_timeout_err = r_timeout_err;
  assign o_stage_idx   = r_stage_idx;
  assign o_round_idx   = r_round_idx;

endmodule

// File: tb/tb_encoder_round_sequencer.sv
// Bench for encoder_round_sequencer: directed job table, randomized jobs against a schedule model, reset corner.
module tb_encoder_round_sequencer;

  localparam int NS   = 4;
  localparam int RW   = 5;
  localparam int TO   = 16;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [RW-1:0] num_rounds;
  logic [NS-1:0] stage_done;
  logic          dp_rst;
  logic          read_file;
  logic          write_file;
  logic [NS-1:0] stage_start;
  logic          finish;
  logic          busy;
  logic          timeout_err;
  logic [1:0]    stage_idx;
  logic [RW-1:0] round_idx;

  always #5 clk = ~clk;

  encoder_round_sequencer #(
    .NUM_STAGES (NS),
    .ROUND_W    (RW),
    .TIMEOUT    (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_abort       (abort),
    .i_num_rounds  (num_rounds),
    .i_stage_done  (stage_done),
    .o_dp_rst      (dp_rst),
    .o_read_file   (read_file),
    .o_write_file  (write_file),
    .o_stage_start (stage_start),
    .o_finish      (finish),
    .o_busy        (busy),
    .o_timeout_err (timeout_err),
    .o_stage_idx   (stage_idx),
    .o_round_idx   (round_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_finish"},      finish,      0);
    check({tag, "_write_file"},  write_file,  0);
    check({tag, "_read_file"},   read_file,   0);
    check({tag, "_dp_rst"},      dp_rst,      0);
    check({tag, "_stage_start"}, stage_start, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_stage_idx"},   stage_idx,   0);
    check({tag, "_round_idx"},   round_idx,   0);
  endtask

  // Directed job: done is returned k cycles after each observed launch (k > TO means never).
  task automatic run_directed(input int rounds, input int k, input logic [NS-1:0] noise,
                              input int abort_c, output int wr_c, output int fin_c,
                              output int np, output int nbusy, output int idle_c,
                              output logic terr_c1, output logic terr_idle);
    int            done_at;
    logic [NS-1:0] done_mask;
    wr_c = -1; fin_c = -1; np = 0; nbusy = 0; idle_c = -1;
    done_at = -1; done_mask = '0; terr_c1 = 1'b0; terr_idle = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c >= 1 && !busy) begin
        idle_c    = c;
        terr_idle = timeout_err;
        break;
      end
      if (busy) nbusy++;
      if (c == 1) terr_c1 = timeout_err;
      if (stage_start != '0) begin
        np++;
        if (k <= TO) begin
          done_at   = c + k;
          done_mask = stage_start;
        end
      end
      if (write_file && wr_c < 0) wr_c = c;
      if (finish && fin_c < 0) fin_c = c;
      start      = (c == 0);
      num_rounds = RW'(rounds);
      abort      = (c == abort_c);
      stage_done = noise | ((c == done_at) ? done_mask : '0);
    end
    start = 1'b0; abort = 1'b0; stage_done = '0;
  endtask

  typedef struct {
    int            rounds;
    int            k;
    logic [NS-1:0] noise;
    int            abort_c;
    int            wr;
    int            fin;
    int            np;
    int            nbusy;
    int            idle;
    logic          terr;
  } vec_t;

  // Expected per-cycle outputs of one job, derived from the stage schedule.
  logic [NS-1:0] m_ss   [MAXC];
  logic [NS-1:0] m_done [MAXC];
  bit            m_wr   [MAXC];
  bit            m_fin  [MAXC];
  bit            m_init [MAXC];
  bit            m_win  [MAXC];
  bit            m_terr [MAXC];
  int            m_stage[MAXC];
  int            m_round[MAXC];

  task automatic run_random(input int rounds);
    int            lc;
    int            k;
    int            fin;
    bit            err;
    logic [NS-1:0] excl;
    for (int c = 0; c < MAXC; c++) begin
      m_ss[c] = '0; m_done[c] = '0; m_wr[c] = 0; m_fin[c] = 0; m_init[c] = 0;
      m_win[c] = 0; m_terr[c] = 0; m_stage[c] = 0; m_round[c] = 0;
    end
    m_init[1] = 1;
    lc = 3; err = 0; fin = 0;
    for (int r = 0; r < rounds && !err; r++) begin
      for (int s = 0; s < NS && !err; s++) begin
        k = $urandom_range(1, TO);
        if ($urandom_range(0, 15) == 0) k = TO + 1;
        m_ss[lc] = NS'(1) << s;
        if (k <= TO) begin
          m_done[lc + k] = NS'(1) << s;
          for (int t = lc; t <= lc + k + 1; t++) begin
            m_win[t] = 1; m_stage[t] = s; m_round[t] = r;
          end
          lc = lc + k + 2;
        end else begin
          for (int t = lc; t <= lc + TO; t++) begin
            m_win[t] = 1; m_stage[t] = s; m_round[t] = r;
          end
          fin = lc + TO + 1;
          err = 1;
        end
      end
    end
    if (!err) begin
      m_wr[lc] = 1;
      fin = lc + 1;
    end
    m_fin[fin] = 1;
    for (int c = fin; c < MAXC; c++) m_terr[c] = err;

    for (int c = 0; c <= fin + 2; c++) begin
      @(negedge clk);
      check("rnd_busy",        busy,        (c >= 1 && c <= fin));
      check("rnd_stage_start", stage_start, m_ss[c]);
      check("rnd_write_file",  write_file,  m_wr[c]);
      check("rnd_finish",      finish,      m_fin[c]);
      check("rnd_dp_rst",      dp_rst,      m_init[c]);
      check("rnd_read_file",   read_file,   m_init[c]);
      if (m_win[c]) begin
        check("rnd_stage_idx", stage_idx, m_stage[c]);
        check("rnd_round_idx", round_idx, m_round[c]);
      end
      if (c >= 1) check("rnd_timeout_err", timeout_err, m_terr[c]);
      excl       = m_win[c] ? (NS'(1) << m_stage[c]) : '0;
      start      = (c == 0) || (c <= fin && $urandom_range(0, 7) == 0);
      num_rounds = (c == 0) ? RW'(rounds) : RW'($urandom);
      stage_done = (NS'($urandom) & ~excl) | m_done[c];
      abort      = 1'b0;
    end
    start = 1'b0; stage_done = '0;
  endtask

  initial begin
    vec_t tbl[7];
    int   wr_c, fin_c, np, nbusy, idle_c, acts;
    logic terr_c1, terr_idle;

    tbl[0] = '{2, 1,  4'b0000, -1, 27, 28,  8, 28, 29, 1'b0};
    tbl[1] = '{0, 1,  4'b0000, -1,  3,  4,  0,  4,  5, 1'b0};
    tbl[2] = '{1, 17, 4'b1110, -1, -1, 20,  1, 20, 21, 1'b1};
    tbl[3] = '{1, 16, 4'b0000, -1, 75, 76,  4, 76, 77, 1'b0};
    tbl[4] = '{2, 1,  4'b0000, 10, -1, -1,  3, 10, 11, 1'b0};
    tbl[5] = '{2, 1,  4'b0000, -1, 27, 28,  8, 28, 29, 1'b0};
    tbl[6] = '{3, 2,  4'b0000, -1, 51, 52, 12, 52, 53, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; num_rounds = '0; stage_done = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_directed(tbl[i].rounds, tbl[i].k, tbl[i].noise, tbl[i].abort_c,
                   wr_c, fin_c, np, nbusy, idle_c, terr_c1, terr_idle);
      check($sformatf("vec%0d_write_cycle", i),  wr_c,      tbl[i].wr);
      check($sformatf("vec%0d_finish_cycle", i), fin_c,     tbl[i].fin);
      check($sformatf("vec%0d_start_pulses", i), np,        tbl[i].np);
      check($sformatf("vec%0d_busy_cycles", i),  nbusy,     tbl[i].nbusy);
      check($sformatf("vec%0d_idle_cycle", i),   idle_c,    tbl[i].idle);
      check($sformatf("vec%0d_terr_cleared", i), terr_c1,   0);
      check($sformatf("vec%0d_terr_idle", i),    terr_idle, tbl[i].terr);
    end

    for (int j = 0; j < 24; j++) begin
      run_random($urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a WAIT.
    @(negedge clk);
    start = 1'b1; num_rounds = RW'(1); stage_done = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midwait_busy_before_reset", busy, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("midwait_reset");
    @(negedge clk);
    rst = 1'b0;
    acts = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy || finish || write_file || read_file || dp_rst || stage_start != '0) acts++;
    end
    check("post_reset_activity", acts, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
